// File: rtl/mfcc_fifo_pkg.sv
// Shared definitions for the MFCC pipeline FIFOs.
//   cnt_width(depth) : bits needed to hold an occupancy of 0..depth
//   ptr_width(depth) : bits needed to address entries 0..depth-1 (at least 1)
//   FIFO_MODE_STD    : registered read, data valid the cycle after the pop
//   FIFO_MODE_FWFT   : head word presented combinationally, pop acknowledges it
package mfcc_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return ($clog2(depth) < 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array for sync_fifo.
// Ports:
//   clk    : clock, write on rising edge
//   we     : write enable
//   waddr  : write address, 0..DEPTH-1
//   wdata  : write data
//   raddr  : read address, 0..DEPTH-1
//   rdata  : asynchronous read data, mem[raddr]
// The storage is deliberately not reset; sync_fifo never exposes an entry
// before it has been written.
module fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with any DEPTH >= 2, standard or first-word-fall-through
// read mode, occupancy count, programmable almost-full/almost-empty flags and
// overflow/underflow error pulses.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   wr_en_i         : push request, write_data_i is the word to push
//   rd_en_i         : pop request (FWFT: acknowledge of the presented word)
//   read_data_o     : popped word (standard) or head word (FWFT, 0 when empty)
//   full_o/empty_o  : count == DEPTH / count == 0
//   almost_full_o   : count >= AF_LEVEL
//   almost_empty_o  : count <= AE_LEVEL
//   count_o         : current occupancy
//   overflow_o      : registered pulse, a push was rejected last cycle
//   underflow_o     : registered pulse, a pop was rejected last cycle
//
// Handshake: the FIFO has no separate ready outputs; full_o/empty_o act as
// the inverted ready. A pop is accepted when rd_en_i && !empty_o. A push is
// accepted when wr_en_i && (!full_o || pop accepted), so a full FIFO takes a
// simultaneous push and pop, while an empty FIFO takes only the push. Any
// rejected request changes nothing except the matching error pulse.
module sync_fifo
  import mfcc_fifo_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 8,
  parameter int FWFT     = FIFO_MODE_STD,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en_i,
  input  logic                        rd_en_i,
  input  logic [WIDTH-1:0]            write_data_i,
  output logic [WIDTH-1:0]            read_data_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic                        almost_full_o,
  output logic                        almost_empty_o,
  output logic [cnt_width(DEPTH)-1:0] count_o,
  output logic                        overflow_o,
  output logic                        underflow_o
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_ae
    $error("sync_fifo: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             ovf_q;
  logic             udf_q;
  logic             rd_ok;
  logic             wr_ok;
  logic [WIDTH-1:0] mem_rdata;

  // Explicit wrap so non-power-of-two depths use exactly DEPTH slots.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign full_o         = (count_q == DEPTH_C);
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= AF_C);
  assign almost_empty_o = (count_q <= AE_C);
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

  assign rd_ok = rd_en_i & ~empty_o;
  assign wr_ok = wr_en_i & (~full_o | rd_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (rd_ok) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      ovf_q <= wr_en_i & ~wr_ok;
      udf_q <= rd_en_i & ~rd_ok;
    end
  end

  // During reset the write is blocked so the cycle leaves storage untouched.
  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok & ~rst),
    .waddr (wr_ptr_q),
    .wdata (write_data_i),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign read_data_o = empty_o ? '0 : mem_rdata;
  end else begin : g_std
    logic [WIDTH-1:0] rdata_q;
    // The array is read asynchronously before the edge, so a full FIFO
    // doing push+pop on the same slot returns the old word.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (rd_ok) begin
        rdata_q <= mem_rdata;
      end
    end
    assign read_data_o = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a standard-mode and an FWFT-mode instance (DEPTH=5,
// AF_LEVEL=4, AE_LEVEL=2) share the same input stimulus and are compared
// every cycle against a queue-based reference model.
module tb_sync_fifo;

  localparam int DEPTH = 5;
  localparam int WIDTH = 8;
  localparam int AF    = 4;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  // clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] wdata = '0;

  logic [WIDTH-1:0] s_rdata, f_rdata;
  logic             s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic             f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [CW-1:0]    s_count, f_count;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .rd_en_i(rd_en), .write_data_i(wdata),
    .read_data_o(s_rdata), .full_o(s_full), .empty_o(s_empty),
    .almost_full_o(s_af), .almost_empty_o(s_ae), .count_o(s_count),
    .overflow_o(s_ovf), .underflow_o(s_udf)
  );

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .rd_en_i(rd_en), .write_data_i(wdata),
    .read_data_o(f_rdata), .full_o(f_full), .empty_o(f_empty),
    .almost_full_o(f_af), .almost_empty_o(f_ae), .count_o(f_count),
    .overflow_o(f_ovf), .underflow_o(f_udf)
  );

  // scoreboard
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_rd = '0;
  logic             exp_ovf = 1'b0;
  logic             exp_udf = 1'b0;
  int               n_vec = 0;
  int               n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: acceptance from pre-edge occupancy, pop before push.
  task automatic model_step(input logic r, input logic w, input logic rd, input logic [WIDTH-1:0] d);
    int  n;
    bit  rd_ok, wr_ok;
    n = exp_q.size();
    if (r) begin
      exp_q.delete();
      exp_rd  = '0;
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      rd_ok = rd && (n > 0);
      wr_ok = w && ((n < DEPTH) || rd_ok);
      if (rd_ok) exp_rd = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(d);
      exp_ovf = w && !wr_ok;
      exp_udf = rd && !rd_ok;
    end
  endtask

  task automatic check_all();
    int n;
    n = exp_q.size();
    check("s_count", 32'(s_count), 32'(n));
    check("f_count", 32'(f_count), 32'(n));
    check("s_full",  32'(s_full),  32'(n == DEPTH));
    check("f_full",  32'(f_full),  32'(n == DEPTH));
    check("s_empty", 32'(s_empty), 32'(n == 0));
    check("f_empty", 32'(f_empty), 32'(n == 0));
    check("s_afull", 32'(s_af),    32'(n >= AF));
    check("f_afull", 32'(f_af),    32'(n >= AF));
    check("s_aempty", 32'(s_ae),   32'(n <= AE));
    check("f_aempty", 32'(f_ae),   32'(n <= AE));
    check("s_ovf",   32'(s_ovf),   32'(exp_ovf));
    check("f_ovf",   32'(f_ovf),   32'(exp_ovf));
    check("s_udf",   32'(s_udf),   32'(exp_udf));
    check("f_udf",   32'(f_udf),   32'(exp_udf));
    check("s_rdata", 32'(s_rdata), 32'(exp_rd));
    check("f_rdata", 32'(f_rdata), (n == 0) ? 32'd0 : 32'(exp_q[0]));
  endtask

  // driver: apply inputs, advance one edge, update model, check away from edge
  task automatic cycle(input logic r, input logic w, input logic rd, input logic [WIDTH-1:0] d);
    rst   = r;
    wr_en = w;
    rd_en = rd;
    wdata = d;
    @(posedge clk);
    model_step(r, w, rd, d);
    #1;
    check_all();
  endtask

  initial begin
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b1, 8'hEE);
    check("rst_empty", 32'(s_empty), 32'd1);
    check("rst_rdata", 32'(s_rdata), 32'd0);

    // fill to full, then one rejected push
    for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h11 * i));
    check("fill_full", 32'(s_full), 32'd1);
    check("fill_count", 32'(s_count), 32'd5);
    cycle(1'b0, 1'b1, 1'b0, 8'h66);
    check("ovf_pulse", 32'(s_ovf), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    check("ovf_drop", 32'(s_ovf), 32'd0);

    // drain in order, then a rejected pop on empty
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      check("drain_word", 32'(s_rdata), 32'(8'h11 * i));
    end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    check("udf_pulse", 32'(s_udf), 32'd1);
    check("udf_hold_rdata", 32'(s_rdata), 32'h55);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);

    // push+pop on empty: push only
    cycle(1'b0, 1'b1, 1'b1, 8'h3C);
    check("empty_rw_count", 32'(s_count), 32'd1);
    check("fwft_head", 32'(f_rdata), 32'h3C);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);

    // full with simultaneous push+pop
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'hA0 + i));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 8'hAA);
      check("full_rw_count", 32'(s_count), 32'd5);
      check("full_rw_word", 32'(s_rdata), 32'(8'hA0 + i));
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
    check("full_rw_last", 32'(s_rdata), 32'hAA);

    // reset mid-operation with a push pending
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h70 + i));
    cycle(1'b1, 1'b1, 1'b0, 8'h99);
    check("midrst_count", 32'(s_count), 32'd0);
    check("midrst_ovf", 32'(s_ovf), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'h5A);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    check("post_rst_word", 32'(s_rdata), 32'h5A);

    // randomized traffic with shifting push/pop bias and rare resets
    for (int ph = 0; ph < 6; ph++) begin
      int wp, rp;
      wp = $urandom_range(20, 90);
      rp = $urandom_range(20, 90);
      for (int i = 0; i < 100; i++) begin
        cycle(($urandom_range(0, 79) == 0),
              ($urandom_range(0, 99) < wp),
              ($urandom_range(0, 99) < rp),
              8'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Parametrised single-clock FIFO, the successor to the basic 8x8 FIFO used between MFCC pipeline stages (sample framing, FFT input, filter-bank output buffering).
- Any DEPTH ≥ 2, not only powers of two; all DEPTH entries usable.
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Occupancy count, programmable almost-full/almost-empty flags, overflow/underflow error pulses.

Parameters:
DEPTH, 8, number of entries, ≥ 2, any integer
WIDTH, 8, data word width in bits, ≥ 1
FWFT, 0, 0 = standard read with registered 1-cycle latency; 1 = head word presented on read_data_o without a request
AF_LEVEL, DEPTH-1, almost_full_o asserts when count ≥ AF_LEVEL, range 1..DEPTH
AE_LEVEL, 1, almost_empty_o asserts when count ≤ AE_LEVEL, range 0..DEPTH-1

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_en_i  in  1  push request
rd_en_i  in  1  pop request
write_data_i  in  WIDTH  push data
read_data_o  out  WIDTH  pop data (standard) or head word (FWFT)
full_o  out  1  count == DEPTH
empty_o  out  1  count == 0
almost_full_o  out  1  count ≥ AF_LEVEL
almost_empty_o  out  1  count ≤ AE_LEVEL
count_o  out  $clog2(DEPTH+1)  current occupancy
overflow_o  out  1  one-cycle pulse: a push was rejected last cycle
underflow_o  out  1  one-cycle pulse: a pop was rejected last cycle

Behaviour:
- Single clock; reset is synchronous and active-high; clock port clk, reset port rst.
- Reset values:
  - read/write pointers 0, count_o 0.
  - empty_o 1, full_o 0, almost_empty_o 1, almost_full_o 0.
  - read_data_o 0, overflow_o 0, underflow_o 0.
  - Storage array is not reset.
- Reset mid-operation discards all contents. Requests in the reset cycle are ignored and produce no error pulse.
- Occupancy: count register drives full_o, empty_o, almost_full_o and almost_empty_o combinationally.
- Pointers: range 0..DEPTH-1; increment wraps from DEPTH-1 to 0 explicitly, with no reliance on power-of-two overflow.
- Acceptance, evaluated on pre-edge state:
  - rd_ok = rd_en_i & !empty_o.
  - wr_ok = wr_en_i & (!full_o | rd_ok).
  - When full, a simultaneous read and write are both accepted; count is unchanged.
  - When empty, a simultaneous read and write: the write is accepted, the read is rejected, count becomes 1.
- Count update: +1 for wr_ok only, -1 for rd_ok only, unchanged for both or neither.
- Standard mode (FWFT=0):
  - On rd_ok, read_data_o <= mem[rd_ptr]. Data is valid the cycle after the request.
  - Otherwise read_data_o holds its value, including on a rejected pop.
  - Full with read+write on the same slot: the read returns the old word (read-before-write).
- FWFT mode (FWFT=1):
  - read_data_o = mem[rd_ptr] combinationally while !empty_o; forced to 0 while empty.
  - rd_en_i acts as an acknowledge of the presented word.
  - A word written into an empty FIFO appears on read_data_o the cycle after the write.
- Errors:
  - overflow_o <= wr_en_i & !wr_ok.
  - underflow_o <= rd_en_i & !rd_ok.
  - Each is a registered pulse, asserted for one cycle per rejected request; back-to-back rejections hold it high.
- Rejected operations do not modify pointers, count or storage.
- Elaboration checks: DEPTH ≥ 2, 1 ≤ AF_LEVEL ≤ DEPTH, 0 ≤ AE_LEVEL < DEPTH. A violation raises $error.

Decomposition:
- Shared package mfcc_fifo_pkg:
  - function cnt_width(depth), returning $clog2(depth+1).
  - function ptr_width(depth), returning max(1, $clog2(depth)).
  - Constants FIFO_MODE_STD = 0, FIFO_MODE_FWFT = 1.
- One sub-module, fifo_mem: DEPTH x WIDTH register array with one synchronous write port and an asynchronous read port.
- sync_fifo holds pointers, count, flags, mode mux and error logic.

Test Plan:
1. DEPTH=5, FWFT=0: push 0x11..0x55 -> full_o=1 after the 5th push, count_o=5. A 6th push -> overflow_o pulses 1 cycle, count stays 5. Pop 5 -> 0x11..0x55 in order, each one cycle after rd_en_i, empty_o=1 at the end.
2. DEPTH=8, full, simultaneous rd+wr of 0xAA for 3 cycles -> count_o stays 8. Outputs are the oldest three words, then 0xAA is read 6th after draining.
3. FWFT=1, empty, push 0x3C -> next cycle read_data_o=0x3C with empty_o=0. Pop -> read_data_o=0, empty_o=1. Pop while empty -> underflow_o pulses, nothing else changes.
4. DEPTH=6, AF_LEVEL=4, AE_LEVEL=2:
   - Push 0..5 -> almost_empty_o deasserts at count 3.
   - almost_full_o asserts at count 4.
   - Both flags track correctly when popping back to 0.
5. DEPTH=3: run 20 push/pop cycles so pointers wrap repeatedly -> data order preserved across wrap, count_o never exceeds 3.
6. Fill 4 words, assert rst for 1 cycle with wr_en_i=1 -> count_o=0, empty_o=1, read_data_o=0, no overflow_o pulse. A subsequent push/pop returns the new data.
